// File: rtl/branch_predictor_if.sv
// Pipeline-facing signals of the branch predictor: the F-stage lookup
// and the D-stage resolve/training bundle. The predictor is the slave.
interface branch_predictor_if #(
  parameter int GHR_W  = 6,
  parameter int STAT_W = 32
);
  // A zero-width history is not representable; keep one tied-off bit.
  localparam int GW = (GHR_W > 0) ? GHR_W : 1;

  // F-stage lookup
  logic [31:0]       f_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [GW-1:0]     f_ghr;

  // D-stage resolve
  logic              d_valid;
  logic              d_stall;
  logic [31:0]       d_pc;
  logic [GW-1:0]     d_ghr;
  logic              d_pred_taken;
  logic [31:0]       d_pred_target;
  logic              d_if_branch;
  logic [31:0]       d_target;
  logic              d_likely;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic              nullify_slot;

  // Statistics
  logic [STAT_W-1:0] hit_cnt;
  logic [STAT_W-1:0] miss_cnt;

  modport master (
    output f_pc, d_valid, d_stall, d_pc, d_ghr, d_pred_taken, d_pred_target,
           d_if_branch, d_target, d_likely,
    input  pred_taken, pred_target, f_ghr, mispredict, redirect_pc,
           nullify_slot, hit_cnt, miss_cnt
  );

  modport slave (
    input  f_pc, d_valid, d_stall, d_pc, d_ghr, d_pred_taken, d_pred_target,
           d_if_branch, d_target, d_likely,
    output pred_taken, pred_target, f_ghr, mispredict, redirect_pc,
           nullify_slot, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// gshare direction predictor with a direct-mapped tagged target store.
// Lookup in F is combinational; training in D is non-speculative, so the
// global history only ever holds resolved outcomes and needs no repair.
module branch_predictor #(
  parameter int IDX_W  = 6,
  parameter int GHR_W  = 6,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;
  localparam int GW      = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0]  cnt_reg [ENTRIES];
  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]  tag_mem [ENTRIES];
  logic [31:0]       tgt_mem [ENTRIES];
  logic [STAT_W-1:0] hit_reg;
  logic [STAT_W-1:0] miss_reg;

  logic              act;
  logic              wrong;
  logic [IDX_W-1:0]  ghr_idx;
  logic [IDX_W-1:0]  d_ghr_idx;
  logic [GW-1:0]     ghr_out;

  logic [IDX_W-1:0]  f_ti;
  logic [IDX_W-1:0]  f_ci;
  logic [TAG_W-1:0]  f_tag;
  logic [IDX_W-1:0]  d_ti;
  logic [IDX_W-1:0]  d_ci;
  logic [TAG_W-1:0]  d_tag;

  // Fetch PC low bits never reach an index; d_ghr is dead when bimodal.
  logic unused_bits;
  assign unused_bits = ^{bp.f_pc[1:0], bp.d_ghr};

  // Holding reset also masks the resolve path so every output reads idle.
  assign act = reset_n & bp.d_valid & ~bp.d_stall;

  assign wrong = (bp.d_pred_taken != bp.d_if_branch) |
                 (bp.d_if_branch & (bp.d_pred_target != bp.d_target));

  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr_reg;

      // Shift in each resolved direction, newest outcome in bit 0.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          ghr_reg <= '0;
        else if (act)
          ghr_reg <= (ghr_reg << 1) | GHR_W'(bp.d_if_branch);
      end

      assign ghr_idx   = IDX_W'(ghr_reg);
      assign d_ghr_idx = IDX_W'(bp.d_ghr);
      assign ghr_out   = ghr_reg;
    end else begin : g_bimodal
      assign ghr_idx   = '0;
      assign d_ghr_idx = '0;
      assign ghr_out   = '0;
    end
  endgenerate

  assign f_ti  = bp.f_pc[IDX_W+1:2];
  assign f_tag = bp.f_pc[31:IDX_W+2];
  assign f_ci  = f_ti ^ ghr_idx;
  assign d_ti  = bp.d_pc[IDX_W+1:2];
  assign d_tag = bp.d_pc[31:IDX_W+2];
  assign d_ci  = d_ti ^ d_ghr_idx;

  // Counters, valid bits and statistics: saturating direction training.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt_reg[i] <= CNT_INIT;
      valid_reg <= '0;
      hit_reg   <= '0;
      miss_reg  <= '0;
    end else if (act) begin
      if (bp.d_if_branch) begin
        if (cnt_reg[d_ci] != CNT_MAX)
          cnt_reg[d_ci] <= cnt_reg[d_ci] + CNT_W'(1);
        valid_reg[d_ti] <= 1'b1;
      end else if (cnt_reg[d_ci] != '0) begin
        cnt_reg[d_ci] <= cnt_reg[d_ci] - CNT_W'(1);
      end
      if (wrong)
        miss_reg <= miss_reg + STAT_W'(1);
      else
        hit_reg <= hit_reg + STAT_W'(1);
    end
  end

  // Target store payload: only taken branches allocate, overwriting any alias.
  always_ff @(posedge clk) begin
    if (act && bp.d_if_branch) begin
      tag_mem[d_ti] <= d_tag;
      tgt_mem[d_ti] <= bp.d_target;
    end
  end

  assign bp.pred_taken   = cnt_reg[f_ci][CNT_W-1] & valid_reg[f_ti] &
                           (tag_mem[f_ti] == f_tag);
  assign bp.pred_target  = bp.pred_taken ? tgt_mem[f_ti] : 32'h0;
  assign bp.f_ghr        = ghr_out;

  assign bp.mispredict   = act & wrong;
  assign bp.redirect_pc  = !act ? 32'h0 :
                           (bp.d_if_branch ? bp.d_target : bp.d_pc + 32'd8);
  assign bp.nullify_slot = act & wrong & bp.d_likely & ~bp.d_if_branch;

  assign bp.hit_cnt      = hit_reg;
  assign bp.miss_cnt     = miss_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal instance carries the main sequence and a
// gshare instance checks history shifting and index hashing.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  branch_predictor_if #(.GHR_W(0), .STAT_W(32)) bp0 ();
  branch_predictor_if #(.GHR_W(6), .STAT_W(32)) bp1 ();

  branch_predictor #(.IDX_W(6), .GHR_W(0), .CNT_W(2), .STAT_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .bp(bp0)
  );
  branch_predictor #(.IDX_W(6), .GHR_W(6), .CNT_W(2), .STAT_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .bp(bp1)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_hit     = 0;
  int   exp_miss    = 0;

  function automatic logic [31:0] observe(string tag);
    case (tag)
      "pred_taken":     return 32'(bp0.pred_taken);
      "pred_target":    return bp0.pred_target;
      "hit":            return bp0.hit_cnt;
      "miss":           return bp0.miss_cnt;
      "mispredict":     return 32'(bp0.mispredict);
      "redirect":       return bp0.redirect_pc;
      "nullify":        return 32'(bp0.nullify_slot);
      "b1_mispredict":  return 32'(bp1.mispredict);
      "b1_f_ghr":       return 32'(bp1.f_ghr);
      "b1_pred_taken":  return 32'(bp1.pred_taken);
      "b1_pred_target": return bp1.pred_target;
      "b1_hit":         return bp1.hit_cnt;
      "b1_miss":        return bp1.miss_cnt;
      default:          return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = observe(e.tag);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
      $display("check %-15s observed=%h expected=%h", e.tag, o, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_check();
    #4;
    check_all();
  endtask

  task automatic drive_res(logic st, logic [31:0] pc, logic pt, logic [31:0] ptg,
                           logic tk, logic [31:0] tg, logic lk);
    bp0.d_valid       = 1'b1;
    bp0.d_stall       = st;
    bp0.d_pc          = pc;
    bp0.d_ghr         = '0;
    bp0.d_pred_taken  = pt;
    bp0.d_pred_target = ptg;
    bp0.d_if_branch   = tk;
    bp0.d_target      = tg;
    bp0.d_likely      = lk;
  endtask

  // Expected resolve outputs; an unstalled resolve also bumps one statistic.
  task automatic exp_res(logic mp, logic [31:0] rpc, logic nl, logic counts);
    expect_val("mispredict", 32'(mp));
    expect_val("redirect", rpc);
    expect_val("nullify", 32'(nl));
    if (counts) begin
      if (mp) exp_miss++;
      else    exp_hit++;
    end
  endtask

  task automatic idle_look(logic [31:0] pc, logic pt, logic [31:0] tgt);
    cyc();
    bp0.d_valid = 1'b0;
    bp0.d_stall = 1'b0;
    bp0.f_pc    = pc;
    expect_val("pred_taken", 32'(pt));
    expect_val("pred_target", tgt);
    expect_val("hit", 32'(exp_hit));
    expect_val("miss", 32'(exp_miss));
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    settle_check();
  endtask

  task automatic res_step(logic [31:0] pc, logic pt, logic [31:0] ptg, logic tk,
                          logic [31:0] tg, logic lk, logic mp, logic [31:0] rpc,
                          logic nl);
    cyc();
    drive_res(1'b0, pc, pt, ptg, tk, tg, lk);
    exp_res(mp, rpc, nl, 1'b1);
    settle_check();
  endtask

  initial begin
    reset_n = 1'b0;
    bp0.f_pc = 32'h3000; bp0.d_valid = 0; bp0.d_stall = 0; bp0.d_pc = 0;
    bp0.d_ghr = '0; bp0.d_pred_taken = 0; bp0.d_pred_target = 0;
    bp0.d_if_branch = 0; bp0.d_target = 0; bp0.d_likely = 0;
    bp1.f_pc = 32'h3000; bp1.d_valid = 0; bp1.d_stall = 0; bp1.d_pc = 0;
    bp1.d_ghr = '0; bp1.d_pred_taken = 0; bp1.d_pred_target = 0;
    bp1.d_if_branch = 0; bp1.d_target = 0; bp1.d_likely = 0;

    // Reset state
    #12;
    expect_val("pred_taken", 0); expect_val("pred_target", 0);
    expect_val("hit", 0); expect_val("miss", 0);
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    expect_val("b1_f_ghr", 0);
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    idle_look(32'h3000, 1'b0, 32'h0);

    // First taken resolve: miss, and F still sees the pre-update table
    cyc();
    drive_res(1'b0, 32'h3000, 1'b0, 32'h0, 1'b1, 32'h3010, 1'b0);
    exp_res(1'b1, 32'h3010, 1'b0, 1'b1);
    expect_val("pred_taken", 0);
    settle_check();
    idle_look(32'h3000, 1'b1, 32'h3010);

    // Two correct taken resolves; counter saturates at 3
    res_step(32'h3000, 1'b1, 32'h3010, 1'b1, 32'h3010, 1'b0, 1'b0, 32'h3010, 1'b0);
    res_step(32'h3000, 1'b1, 32'h3010, 1'b1, 32'h3010, 1'b0, 1'b0, 32'h3010, 1'b0);
    idle_look(32'h3000, 1'b1, 32'h3010);

    // Not-taken after saturation: still predicted taken (counter 2)
    res_step(32'h3000, 1'b1, 32'h3010, 1'b0, 32'h3010, 1'b0, 1'b1, 32'h3008, 1'b0);
    idle_look(32'h3000, 1'b1, 32'h3010);

    // Likely branch wrongly predicted taken: slot nullified, now not taken
    res_step(32'h3000, 1'b1, 32'h3010, 1'b0, 32'h3010, 1'b1, 1'b1, 32'h3008, 1'b1);
    idle_look(32'h3000, 1'b0, 32'h0);

    // Aliasing: 0x3100 shares the entry and evicts 0x3000's tag
    res_step(32'h3000, 1'b0, 32'h0, 1'b1, 32'h3010, 1'b0, 1'b1, 32'h3010, 1'b0);
    res_step(32'h3100, 1'b0, 32'h0, 1'b1, 32'h3200, 1'b0, 1'b1, 32'h3200, 1'b0);
    idle_look(32'h3000, 1'b0, 32'h0);
    idle_look(32'h3100, 1'b1, 32'h3200);

    // Right direction, wrong target is a mispredict
    res_step(32'h3100, 1'b1, 32'h3200, 1'b1, 32'h3300, 1'b0, 1'b1, 32'h3300, 1'b0);
    // Correct not-taken: fall-through redirect, entry not invalidated
    res_step(32'h3100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3108, 1'b0);
    idle_look(32'h3100, 1'b1, 32'h3300);

    // Fall-through address wraps at 2^32
    res_step(32'hFFFF_FFFC, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);

    // Stalled branch: no effect for three cycles, then exactly one resolve
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive_res(1'b1, 32'h3040, 1'b0, 32'h0, 1'b1, 32'h3080, 1'b0);
      exp_res(1'b0, 32'h0, 1'b0, 1'b0);
      settle_check();
    end
    res_step(32'h3040, 1'b0, 32'h0, 1'b1, 32'h3080, 1'b0, 1'b1, 32'h3080, 1'b0);
    idle_look(32'h3040, 1'b1, 32'h3080);
    // One not-taken drops it back below threshold only if trained once
    res_step(32'h3040, 1'b1, 32'h3080, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3048, 1'b0);
    idle_look(32'h3040, 1'b0, 32'h0);

    // Asynchronous reset mid-operation
    cyc();
    bp0.f_pc = 32'h3100;
    drive_res(1'b0, 32'h3100, 1'b0, 32'h0, 1'b1, 32'h3300, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    exp_hit = 0;
    exp_miss = 0;
    expect_val("pred_taken", 0); expect_val("pred_target", 0);
    expect_val("hit", 0); expect_val("miss", 0);
    exp_res(1'b0, 32'h0, 1'b0, 1'b0);
    check_all();
    bp0.d_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle_look(32'h3100, 1'b0, 32'h0);

    // gshare instance: history shift and XOR indexing
    cyc();
    bp1.d_valid = 1'b1; bp1.d_pc = 32'h3000; bp1.d_ghr = 6'd2;
    bp1.d_pred_taken = 1'b0; bp1.d_pred_target = 32'h0;
    bp1.d_if_branch = 1'b1; bp1.d_target = 32'h3010; bp1.f_pc = 32'h3000;
    expect_val("b1_mispredict", 1);
    expect_val("b1_f_ghr", 0);
    settle_check();
    cyc();
    bp1.d_valid = 1'b0;
    expect_val("b1_f_ghr", 1);
    expect_val("b1_pred_taken", 0);
    settle_check();
    cyc();
    bp1.d_valid = 1'b1; bp1.d_pc = 32'h3100; bp1.d_ghr = 6'd0;
    bp1.d_if_branch = 1'b0; bp1.d_target = 32'h0;
    expect_val("b1_mispredict", 0);
    settle_check();
    cyc();
    bp1.d_valid = 1'b0;
    expect_val("b1_f_ghr", 2);
    expect_val("b1_pred_taken", 1);
    expect_val("b1_pred_target", 32'h3010);
    expect_val("b1_hit", 1);
    expect_val("b1_miss", 1);
    settle_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the MIPS pipeline. Predicts branch direction and target in F, and is trained in D when the branch comparator resolves. The prediction structure is a gshare table of saturating counters plus a direct-mapped, tagged branch target store. Raises a one-cycle mispredict/redirect to the pipeline and keeps hit/miss statistics; it covers ordinary and "likely" branches, including delay-slot nullification on a wrong-taken likely branch.

## Interface
Parameters:
- IDX_W, 6: index width; both tables have 2^IDX_W entries.
- GHR_W, 6: global history width, 0..IDX_W; 0 gives pure bimodal indexing.
- CNT_W, 2: counter width, 2..4.
- STAT_W, 32: width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_pc  in  32  fetch PC.
- pred_taken  out  1  predict taken for f_pc (combinational).
- pred_target  out  32  predicted target; 0 when pred_taken=0.
- f_ghr  out  GHR_W  history snapshot; the pipeline carries it with the instruction.
- d_valid  in  1  a conditional branch occupies D this cycle.
- d_stall  in  1  D is stalled; blocks training, statistics and redirect.
- d_pc  in  32  PC of the branch in D.
- d_ghr  in  GHR_W  f_ghr carried from F.
- d_pred_taken  in  1  carried pred_taken.
- d_pred_target  in  32  carried pred_target.
- d_if_branch  in  1  resolved direction from the comparator.
- d_target  in  32  resolved taken target.
- d_likely  in  1  branch is a likely variant.
- mispredict  out  1  redirect fetch this cycle.
- redirect_pc  out  32  redirect address.
- nullify_slot  out  1  the delay slot must be squashed.
- hit_cnt  out  STAT_W  count of correct predictions.
- miss_cnt  out  STAT_W  count of mispredictions.

## Operation
Lookup (F, combinational):
- Counter index: fi = f_pc[IDX_W+1:2] XOR {ghr, zero-padded to IDX_W}.
- Target index: ti = f_pc[IDX_W+1:2]. Tag = f_pc[31:IDX_W+2].
- pred_taken = cnt[fi] MSB & valid[ti] & (tag[ti] == f_pc tag).
- pred_target = pred_taken ? tgt[ti] : 0.
- f_ghr = ghr.

Resolve (D, combinational), with act = d_valid & !d_stall:
- wrong = d_pred_taken != d_if_branch, or (d_if_branch and d_pred_target != d_target).
- mispredict = act & wrong.
- redirect_pc = d_if_branch ? d_target : d_pc + 8 (32-bit wrap).
- nullify_slot = mispredict & d_likely & !d_if_branch.
- When act=0, all three outputs are 0 and redirect_pc is 0.

Training (rising edge, when act=1):
- Counter update: cnt[d_pc[IDX_W+1:2] XOR d_ghr] increments, saturating at 2^CNT_W-1, if d_if_branch; otherwise it decrements, saturating at 0.
- If d_if_branch: the target entry at d_pc[IDX_W+1:2] becomes valid with the d_pc tag and d_target, overwriting any previous occupant.
- Not-taken branches never allocate and never invalidate a target entry.
- ghr <= {ghr[GHR_W-2:0], d_if_branch}. Training is non-speculative; no GHR repair is needed.
- Statistics: hit_cnt increments if !wrong, miss_cnt increments if wrong. Both wrap at 2^STAT_W.

## Timing
- Reset (asynchronous assert, release synchronous to clk):
  - every counter = weakly not-taken, i.e. MSB 0 and remaining bits 1 (01 for CNT_W=2);
  - all valid bits = 0; ghr = 0; hit_cnt = miss_cnt = 0;
  - therefore pred_taken = 0, pred_target = 0, mispredict = 0, nullify_slot = 0, redirect_pc = 0.
- Lookup latency is 0 cycles. Training is visible to F on the cycle after the edge that wrote it.
- Same-entry read and write in one cycle: F sees the pre-update value.
- Resolve outputs are valid in the same cycle as d_valid.
- A stalled branch (d_stall=1) produces no effect; it resolves once, in the cycle it leaves D.
- reset_n asserted mid-operation clears state immediately and drops every output to its reset value.
- GHR_W=0: ghr and f_ghr are removed or tied off, and indexing is bimodal.

## Test plan
- Reset, then f_pc=0x3000 -> pred_taken=0, pred_target=0; hit_cnt=miss_cnt=0.
- Branch 0x3000 with GHR_W=0, taken to 0x3010, resolved 3 times -> first resolve: mispredict=1, redirect_pc=0x3010; afterwards pred_taken=1, pred_target=0x3010; counter saturates at 3; hit_cnt=2, miss_cnt=1.
- Same branch after saturation, resolved not-taken -> mispredict=1, redirect_pc=0x3008; the next prediction is still taken (counter=2); one more not-taken makes pred_taken=0.
- Likely branch predicted taken, resolves not-taken -> mispredict=1, nullify_slot=1, redirect_pc=d_pc+8. A non-likely branch in the same case gives nullify_slot=0.
- Alias: 0x3000 and 0x3100 (IDX_W=6) both taken, to different targets -> the second overwrites the tag; lookup at 0x3000 gives pred_taken=0.
- d_valid=1 with d_stall=1 for 3 cycles, then d_stall=0 -> exactly one update and one statistic increment. reset_n pulsed low mid-sequence returns all outputs to reset values asynchronously.
